rf_wb_arbiter: RTL

//  Arbitrates the single regfile write port between the in-order writeback stage and an
//  out-of-band long-latency unit (divider / uncached load) whose results return late.

---
 rtl/rf_wb_arbiter_if.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if
//   Bus bundle between the writeback stage, the long-latency unit, the hazard
//   unit and the regfile write port.
//   master : drives pipe_*, ll_issue*, ll_valid/ll_rd/ll_data; observes the rest
//   slave  : the arbiter; drives stall_o, ll_ready, busy_o, reg_*
interface rf_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_idx;
  logic [31:0] pipe_data;
  logic        stall_o;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic [31:0] busy_o;
  logic        reg_we;
  logic [4:0]  reg_idx;
  logic [31:0] reg_data;

  modport master (
    output pipe_we, pipe_idx, pipe_data, ll_issue, ll_issue_rd,
           ll_valid, ll_rd, ll_data,
    input  stall_o, ll_ready, busy_o, reg_we, reg_idx, reg_data
  );

  modport slave (
    input  pipe_we, pipe_idx, pipe_data, ll_issue, ll_issue_rd,
           ll_valid, ll_rd, ll_data,
    output stall_o, ll_ready, busy_o, reg_we, reg_idx, reg_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single regfile write port between in-order writeback and late
//   results from a long-latency unit. Late results that lose arbitration wait
//   in a DEPTH-entry FIFO; a starvation counter forces a drain after
//   STARVE_MAX consecutive pipe wins. busy_o marks registers with a pending
//   late write for the hazard unit.
//   clk, rst_n : clock, async active-low reset
//   bus        : rf_wb_arbiter_if.slave (writeback, late-result, busy, regfile)
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wb_arbiter_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } late_t;

  late_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic [31:0]       busy_q, busy_d;

  logic        empty, full, push, pop, bypass, force_drain, stall;
  logic        wr_sel;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  late_t       head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Grant selection, highest priority first.
  always_comb begin
    force_drain = bus.pipe_we & ~empty & (starve_q == SW'(STARVE_MAX));
    pop     = 1'b0;
    bypass  = 1'b0;
    stall   = 1'b0;
    wr_sel  = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (force_drain) begin
      pop = 1'b1; stall = 1'b1; wr_sel = 1'b1;
      wr_idx = head.rd; wr_data = head.data;
    end else if (bus.pipe_we) begin
      wr_sel = 1'b1;
      wr_idx = bus.pipe_idx; wr_data = bus.pipe_data;
    end else if (!empty) begin
      pop = 1'b1; wr_sel = 1'b1;
      wr_idx = head.rd; wr_data = head.data;
    end else if (bus.ll_valid) begin
      bypass = 1'b1; wr_sel = 1'b1;
      wr_idx = bus.ll_rd; wr_data = bus.ll_data;
    end
  end

  // ll_ready looks only at full, so a full FIFO refuses even while popping.
  // A bypassed result is written directly and never enters the FIFO.
  assign push = bus.ll_valid & ~full & ~bypass;

  // Pops and an empty FIFO reset the count; otherwise a non-empty FIFO that
  // did not pop means the pipe won.
  always_comb begin
    starve_d = starve_q;
    if (pop || empty)                      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))  starve_d = starve_q + 1'b1;
  end

  // Clear before set so a same-cycle reissue to the same register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop)          busy_d[head.rd]         = 1'b0;
    if (bypass)       busy_d[bus.ll_rd]       = 1'b0;
    if (bus.ll_issue) busy_d[bus.ll_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{rd: bus.ll_rd, data: bus.ll_data};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  // x0 writes still consume their slot but never reach the regfile.
  assign bus.reg_we   = wr_sel & (wr_idx != 5'd0);
  assign bus.reg_idx  = wr_idx;
  assign bus.reg_data = wr_data;
  assign bus.stall_o  = stall;
  assign bus.ll_ready = ~full;
  assign bus.busy_o   = busy_q;
endmodule
